// File: rtl/cpu_pkg.sv
// Shared constants and the fetch buffer entry type used by the fetch stage.
package cpu_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE0000000;
    localparam int          PC_STEP   = 4;
    localparam int          PC_OFS_D  = 8;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with clear; DEPTH must be a power of two so pointers wrap by overflow.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T                mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            count_r <= count_r + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push && !(reset || clr)) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with credit-limited in-order memory requests, a return buffer
// that discards stale responses after a redirect, and the IF/ID pipeline register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = {BITS{1'b0}},
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            BranchTakenE,
    input  logic [BITS-1:0] BranchTargetE,
    output logic            ImemReq,
    output logic [BITS-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRValid,
    input  logic [BITS-1:0] ImemRData,
    output logic [BITS-1:0] InstrD,
    output logic [BITS-1:0] PCPlus8D,
    output logic            ValidD
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [BITS-1:0] pcf_r;
    logic [CW-1:0]   drop_r;
    logic [BITS-1:0] instr_r;
    logic [BITS-1:0] pc8_r;
    logic            valid_r;

    // The PC queue occupancy is exactly the number of requests in flight
    logic [CW-1:0]   inflight_s;
    logic [CW-1:0]   data_count_s;
    logic [BITS-1:0] pcq_head_s;
    fetch_entry_t    data_head_s;
    fetch_entry_t    rsp_entry_s;
    fetch_entry_t    take_entry_s;
    logic            data_empty_s;
    logic            grant_s;
    logic            rsp_s;
    logic            acc_s;
    logic            take_s;
    logic            pop_s;
    logic            push_s;

    // Request credit, response classification and IF/ID source selection
    always_comb begin
        data_empty_s      = (data_count_s == {CW{1'b0}});
        ImemReq           = !reset && !StallF && !BranchTakenE &&
                            (({1'b0, inflight_s} + {1'b0, data_count_s}) < (CW+1)'(DEPTH));
        grant_s           = ImemReq && ImemGnt;
        rsp_s             = ImemRValid && (inflight_s != {CW{1'b0}});
        acc_s             = rsp_s && (drop_r == {CW{1'b0}}) && !BranchTakenE;
        rsp_entry_s.instr = XLEN'(ImemRData);
        rsp_entry_s.pc    = XLEN'(pcq_head_s);
        take_s            = !reset && !FlushD && !StallD && !BranchTakenE &&
                            (!data_empty_s || acc_s);
        pop_s             = take_s && !data_empty_s;
        // An accepted word goes straight to IF/ID when the buffer is empty
        push_s            = acc_s && !(take_s && data_empty_s);
        if (data_empty_s) begin
            take_entry_s = rsp_entry_s;
        end else begin
            take_entry_s = data_head_s;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [BITS-1:0])) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .push  (grant_s),
        .pop   (rsp_s),
        .din   (pcf_r),
        .dout  (pcq_head_s),
        .count (inflight_s)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (BranchTakenE),
        .push  (push_s),
        .pop   (pop_s),
        .din   (rsp_entry_s),
        .dout  (data_head_s),
        .count (data_count_s)
    );

    // Fetch PC and count of responses still owed by requests older than a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_r  <= RESET_PC;
            drop_r <= {CW{1'b0}};
        end else if (BranchTakenE) begin
            pcf_r  <= BranchTargetE;
            drop_r <= inflight_s - CW'(rsp_s);
        end else begin
            if (grant_s) pcf_r <= pcf_r + BITS'(PC_STEP);
            if (rsp_s && (drop_r != {CW{1'b0}})) drop_r <= drop_r - CW'(1'b1);
        end
    end

    // IF/ID register: flush beats stall, otherwise load or insert a bubble
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            valid_r <= 1'b0;
            instr_r <= BITS'(NOP_INSTR);
            pc8_r   <= {BITS{1'b0}};
        end else if (StallD) begin
            valid_r <= valid_r;
        end else if (take_s) begin
            valid_r <= 1'b1;
            instr_r <= BITS'(take_entry_s.instr);
            pc8_r   <= BITS'(take_entry_s.pc) + BITS'(PC_OFS_D);
        end else begin
            valid_r <= 1'b0;
            instr_r <= BITS'(NOP_INSTR);
            pc8_r   <= {BITS{1'b0}};
        end
    end

    assign ImemAddr = pcf_r;
    assign InstrD   = instr_r;
    assign PCPlus8D = pc8_r;
    assign ValidD   = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for streaming and decode stall,
// plus hand sequences for redirect, flush, grant back-pressure, PC wrap and reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, BranchTakenE;
    logic [31:0] BranchTargetE;
    logic        ImemReq, ImemGnt, ImemRValid;
    logic [31:0] ImemAddr, ImemRData;
    logic [31:0] InstrD, PCPlus8D;
    logic        ValidD;

    int nvec = 0;
    int nmis = 0;
    int lat  = 1;
    int mcyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    typedef struct {
        logic        stallf, stalld, flushd, br;
        logic [31:0] tgt;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pc8;
    } vec_t;
    vec_t vecs[12];

    fetch_stage #(.BITS(32), .RESET_PC(32'h100), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A000000;
    endfunction

    function automatic vec_t mk(input logic sd, input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] instr, input logic [31:0] pc8);
        vec_t v;
        v.stallf = 1'b0; v.stalld = sd; v.flushd = 1'b0; v.br = 1'b0; v.tgt = 32'h0; v.gnt = 1'b1;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc8 = pc8;
        return v;
    endfunction

    // In-order memory with fixed latency: grant in cycle t answers in cycle t+lat
    initial begin
        logic        g, r, rs;
        logic [31:0] a;
        ImemRValid = 1'b0;
        ImemRData  = 32'h0;
        forever begin
            @(negedge clk);
            g = ImemReq && ImemGnt; a = ImemAddr; r = ImemRValid; rs = reset;
            @(posedge clk);
            #1;
            if (rs) begin
                pend.delete();
            end else begin
                if (r) void'(pend.pop_front());
                if (g) pend.push_back('{addr: a, due: mcyc + lat});
            end
            mcyc++;
            if (pend.size() > 0 && pend[0].due <= mcyc) begin
                ImemRValid = 1'b1;
                ImemRData  = memword(pend[0].addr);
            end else begin
                ImemRValid = 1'b0;
                ImemRData  = 32'h0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; BranchTargetE = 32'h0; ImemGnt = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b1, 32'h100, 1'b0, 32'hE0000000, 32'h0);
        vecs[1]  = mk(1'b0, 1'b1, 32'h104, 1'b0, 32'hE0000000, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 32'h108, 1'b1, 32'h5A000100, 32'h108);
        vecs[3]  = mk(1'b0, 1'b1, 32'h10C, 1'b1, 32'h5A000104, 32'h10C);
        vecs[4]  = mk(1'b0, 1'b1, 32'h110, 1'b1, 32'h5A000108, 32'h110);
        vecs[5]  = mk(1'b1, 1'b1, 32'h114, 1'b1, 32'h5A00010C, 32'h114);
        vecs[6]  = mk(1'b1, 1'b0, 32'h118, 1'b1, 32'h5A00010C, 32'h114);
        vecs[7]  = mk(1'b1, 1'b0, 32'h118, 1'b1, 32'h5A00010C, 32'h114);
        vecs[8]  = mk(1'b0, 1'b0, 32'h118, 1'b1, 32'h5A00010C, 32'h114);
        vecs[9]  = mk(1'b0, 1'b1, 32'h118, 1'b1, 32'h5A000110, 32'h118);
        vecs[10] = mk(1'b0, 1'b1, 32'h11C, 1'b1, 32'h5A000114, 32'h11C);
        vecs[11] = mk(1'b0, 1'b1, 32'h120, 1'b1, 32'h5A000118, 32'h120);

        // Streaming with L=1, then StallD for three cycles while the buffer fills
        lat = 1;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            StallF = vecs[i].stallf; StallD = vecs[i].stalld; FlushD = vecs[i].flushd;
            BranchTakenE = vecs[i].br; BranchTargetE = vecs[i].tgt; ImemGnt = vecs[i].gnt;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i),   ImemReq,  vecs[i].req);
            chk($sformatf("vec%0d_addr", i),  ImemAddr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), ValidD,   vecs[i].valid);
            chk($sformatf("vec%0d_instr", i), InstrD,   vecs[i].instr);
            chk($sformatf("vec%0d_pc8", i),   PCPlus8D, vecs[i].pc8);
            next_cycle();
        end

        // Redirect to 0x200 with two requests in flight, L=3
        lat = 3;
        do_reset();
        ImemGnt = 1'b1;
        @(negedge clk); chk("redir_c0_addr", ImemAddr, 32'h100); next_cycle();
        @(negedge clk); chk("redir_c1_addr", ImemAddr, 32'h104); next_cycle();
        BranchTakenE = 1'b1; BranchTargetE = 32'h200;
        @(negedge clk); chk("redir_c2_req", ImemReq, 1'b0); next_cycle();
        BranchTakenE = 1'b0; BranchTargetE = 32'h0;
        for (int c = 3; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("redir_c%0d_valid", c), ValidD, 1'b0);
            if (c == 3) chk("redir_c3_addr", ImemAddr, 32'h200);
            if (c == 4) chk("redir_c4_req", ImemReq, 1'b1);
            next_cycle();
        end
        StallD = 1'b1; FlushD = 1'b1;
        @(negedge clk);
        chk("redir_c8_valid", ValidD, 1'b1);
        chk("redir_c8_instr", InstrD, 32'h5A000200);
        chk("redir_c8_pc8", PCPlus8D, 32'h208);
        next_cycle();
        // Flush together with stall yields a bubble; buffered word follows next
        StallD = 1'b0; FlushD = 1'b0;
        @(negedge clk);
        chk("flush_valid", ValidD, 1'b0);
        chk("flush_instr", InstrD, 32'hE0000000);
        chk("flush_pc8", PCPlus8D, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("after_flush_valid", ValidD, 1'b1);
        chk("after_flush_pc8", PCPlus8D, 32'h20C);
        next_cycle();

        // Grant withheld for five cycles
        lat = 1;
        do_reset();
        ImemGnt = 1'b1;
        @(negedge clk); chk("gnt_c0_addr", ImemAddr, 32'h100); next_cycle();
        ImemGnt = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("gnt_c%0d_req", c), ImemReq, 1'b1);
            chk($sformatf("gnt_c%0d_addr", c), ImemAddr, 32'h104);
            chk($sformatf("gnt_c%0d_valid", c), ValidD, (c == 2) ? 1'b1 : 1'b0);
            next_cycle();
        end
        ImemGnt = 1'b1;
        next_cycle();
        next_cycle();
        // Reset in the middle of the stream
        reset = 1'b1;
        @(negedge clk); chk("rst_req_low", ImemReq, 1'b0); next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", ValidD, 1'b0);
        chk("rst_addr", ImemAddr, 32'h100);
        chk("rst_req", ImemReq, 1'b1);
        next_cycle();
        @(negedge clk); chk("rst_c1_valid", ValidD, 1'b0); next_cycle();
        @(negedge clk);
        chk("rst_c2_instr", InstrD, 32'h5A000100);
        chk("rst_c2_pc8", PCPlus8D, 32'h108);
        next_cycle();

        // Redirect to the top of the address space and wrap
        lat = 1;
        do_reset();
        ImemGnt = 1'b1;
        @(negedge clk); chk("wrap_c0_addr", ImemAddr, 32'h100); next_cycle();
        BranchTakenE = 1'b1; BranchTargetE = 32'hFFFFFFFC;
        @(negedge clk); chk("wrap_c1_valid", ValidD, 1'b0); next_cycle();
        BranchTakenE = 1'b0; BranchTargetE = 32'h0;
        @(negedge clk);
        chk("wrap_c2_addr", ImemAddr, 32'hFFFFFFFC);
        chk("wrap_c2_valid", ValidD, 1'b0);
        next_cycle();
        @(negedge clk); chk("wrap_c3_addr", ImemAddr, 32'h0); next_cycle();
        @(negedge clk);
        chk("wrap_c4_valid", ValidD, 1'b1);
        chk("wrap_c4_instr", InstrD, 32'hA5FFFFFC);
        chk("wrap_c4_pc8", PCPlus8D, 32'h4);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
